uart_rx_frontend: RTL and testbench

//   Serial receive front end for the board's com_RxD pin, upstream of the SOPC's UART register block.

---
 rtl/uart_rx_frontend.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// ============================================================================
// uart_rx_frontend
// ----------------------------------------------------------------------------
// Serial receive front end for the com_RxD pin. The asynchronous line is
// synchronised, oversampled at 16x and each bit is decided by a 2-of-3
// majority of the samples at s=7,8,9. 8N1 characters (8E1 when
// UART_RX_PARITY_EN is defined) are deframed LSB first. Each good byte is
// presented through a single-entry valid/ready holding register. Frame,
// overrun and parity problems are reported on sticky error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : an even-parity bit follows the data bits (11-bit frame).
//               A mismatch sets parity_err and the byte is discarded.
//   undefined : 10-bit frame; parity_err is constant 0.
//
// Parameters
//   OSR_DIV      clk cycles per 1/16 bit period (must be >= 2)
//   SYNC_STAGES  synchroniser depth on com_RxD (2..3)
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   com_RxD      in   asynchronous serial line, idle high
//   rx_data      out  received byte, meaningful while rx_valid=1
//   rx_valid     out  holding register full
//   rx_ready     in   consumer accepts; transfer when rx_valid & rx_ready
//   frame_err    out  sticky: stop bit decided 0
//   overrun_err  out  sticky: byte completed while holding register full
//   parity_err   out  sticky: parity mismatch (macro builds only)
//   err_clr      in   clears all sticky flags (a new error wins)
//   busy         out  receiver FSM not idle
// ============================================================================
module uart_rx_frontend #(
    parameter int OSR_DIV     = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       com_RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    input  logic       err_clr,
    output logic       busy
);

    localparam int DIV_W = (OSR_DIV > 2) ? $clog2(OSR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_BRKWAIT = 3'd5
    } state_t;

    // 2-of-3 vote used for every bit decision
    function automatic logic f_majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity bit: the value that makes the total count of ones even
    function automatic logic f_even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    logic [DIV_W-1:0]       r_div;
    state_t                 r_state;
    logic [3:0]             r_s;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic [1:0]             r_smp;
    logic                   r_par_bad;
    logic                   r_busy;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_overrun_err;
    logic                   r_parity_err;

    logic                   w_rxd;
    logic                   w_fall;
    logic                   w_tick;
    logic                   w_div_restart;
    logic                   w_maj;
    logic                   w_decide;
    logic                   w_bit_end;
    logic [3:0]             w_s_inc;
    state_t                 w_state_nxt;
    logic [3:0]             w_s_nxt;
    logic [2:0]             w_idx_nxt;
    logic [7:0]             w_shift_nxt;
    logic [1:0]             w_smp_nxt;
    logic                   w_par_bad_nxt;
    logic                   w_deliver;
    logic                   w_set_frame;
    logic                   w_set_parity;
    logic                   w_set_overrun;

    assign w_rxd         = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_rxd_prev & ~w_rxd;
    assign w_tick        = (r_div == DIV_LAST);
    assign w_div_restart = (r_state == ST_IDLE) & w_fall;
    // Third vote comes straight from the line at the s=9 decision tick
    assign w_maj         = f_majority3(r_smp[0], r_smp[1], w_rxd);
    assign w_decide      = w_tick & (r_s == 4'd9);
    assign w_bit_end     = w_tick & (r_s == 4'd15);
    assign w_s_inc       = w_tick ? (r_s + 4'd1) : r_s;
    assign w_set_overrun = w_deliver & r_rx_valid & ~rx_ready;

    // Line synchroniser plus one extra flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= {SYNC_STAGES{1'b1}};
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], com_RxD};
            r_rxd_prev <= w_rxd;
        end
    end

    // Oversampling tick divider, re-phased on a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= {DIV_W{1'b0}};
        end else if (w_div_restart || w_tick) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Next-state, datapath and event logic of the deframing FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_s_nxt       = r_s;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_par_bad_nxt = r_par_bad;
        w_deliver     = 1'b0;
        w_set_frame   = 1'b0;
        w_set_parity  = 1'b0;

        // Capture the first two votes of the current bit
        w_smp_nxt = r_smp;
        if (w_tick && (r_s == 4'd7)) begin
            w_smp_nxt[0] = w_rxd;
        end else if (w_tick && (r_s == 4'd8)) begin
            w_smp_nxt[1] = w_rxd;
        end else begin
            w_smp_nxt = r_smp;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = ST_START;
                    w_s_nxt       = 4'd0;
                    w_par_bad_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_s_nxt = w_s_inc;
                // A start bit that votes high is a glitch, not a character
                if (w_decide && w_maj) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                w_s_nxt = w_s_inc;
                if (w_decide) begin
                    w_shift_nxt[r_idx] = w_maj;
                end else begin
                    w_shift_nxt = r_shift;
                end
                if (w_bit_end && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                    w_idx_nxt = 3'd0;
                end else if (w_bit_end) begin
                    w_idx_nxt = r_idx + 3'd1;
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                w_s_nxt = w_s_inc;
                if (w_decide && (w_maj != f_even_parity(r_shift))) begin
                    w_set_parity  = 1'b1;
                    w_par_bad_nxt = 1'b1;
                end else begin
                    w_par_bad_nxt = r_par_bad;
                end
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                w_s_nxt = w_s_inc;
                // Leave at s=9 so a start edge in the second half of the
                // stop bit is not missed
                if (w_decide && w_maj) begin
                    w_state_nxt = ST_IDLE;
                    w_deliver   = ~r_par_bad;
                end else if (w_decide) begin
                    w_state_nxt = ST_BRKWAIT;
                    w_set_frame = 1'b1;
                    w_s_nxt     = 4'd0;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_BRKWAIT: begin
                // r_s counts consecutive high ticks; any low tick restarts it
                if (w_tick && w_rxd && (r_s == 4'd15)) begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = 4'd0;
                end else if (w_tick && w_rxd) begin
                    w_s_nxt = r_s + 4'd1;
                end else if (w_tick) begin
                    w_s_nxt = 4'd0;
                end else begin
                    w_s_nxt = r_s;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = 4'd0;
            end
        endcase
    end

    // FSM state and bit-timing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_s       <= 4'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_smp     <= 2'b00;
            r_par_bad <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s       <= w_s_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_smp     <= w_smp_nxt;
            r_par_bad <= w_par_bad_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Single-entry holding register; a byte arriving while full and not
    // being drained is dropped so the consumer keeps the older byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else if (w_deliver && (!r_rx_valid || rx_ready)) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= r_rx_valid;
        end
    end

    // Sticky error flags; a new error takes priority over err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            r_frame_err   <= (r_frame_err   & ~err_clr) | w_set_frame;
            r_overrun_err <= (r_overrun_err & ~err_clr) | w_set_overrun;
            r_parity_err  <= (r_parity_err  & ~err_clr) | w_set_parity;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign parity_err  = r_parity_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at OSR_DIV=4 (one bit = 64 clk).
// A serial transmitter drives frames; a reference model derived from the
// framing rules pushes the bytes expected at the consumer into a queue and
// tracks the expected sticky flags. A monitor pops and compares on every
// rx_valid & rx_ready transfer.
module tb_uart_rx_frontend;

    localparam int OSR = 4;
    localparam int BIT = 16 * OSR;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       com_RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;
    logic       err_clr;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       exp_frame   = 1'b0;
    logic       exp_overrun = 1'b0;
    logic       exp_parity  = 1'b0;
    logic       model_full  = 1'b0;
    logic [7:0] model_held  = 8'h00;

    uart_rx_frontend #(.OSR_DIV(OSR), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .com_RxD     (com_RxD),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every transfer must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rx_byte got=%02h expected=none", rx_data);
            end else if (rx_data !== exp_q[0]) begin
                bad++;
                $display("FAIL rx_byte got=%02h expected=%02h", rx_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        com_RxD = v;
        tick_n(n);
    endtask

    // Start bit, 8 data bits LSB first, and the parity bit when enabled
    task automatic send_body(input logic [7:0] d, input int per, input bit par_flip);
        hold(1'b0, per);
        for (int i = 0; i < 8; i++) hold(d[i], per);
        if (PAR_EN) hold((^d) ^ par_flip, per);
    endtask

    // Reference model for a frame whose stop bit is 1
    task automatic model_good_frame(input logic [7:0] d, input bit par_flip);
        if (PAR_EN && par_flip) begin
            exp_parity = 1'b1;
        end else if (model_full) begin
            exp_overrun = 1'b1;
        end else if (rx_ready) begin
            exp_q.push_back(d);
        end else begin
            model_full = 1'b1;
            model_held = d;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input bit par_flip);
        send_body(d, per, par_flip);
        model_good_frame(d, par_flip);
        hold(1'b1, per);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick_n(1);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"},   frame_err,   exp_frame);
        check({tag, "_overrun_err"}, overrun_err, exp_overrun);
        check({tag, "_parity_err"},  parity_err,  exp_parity);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick_n(1);
        err_clr = 1'b0;
        exp_frame   = 1'b0;
        exp_overrun = 1'b0;
        exp_parity  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        com_RxD  = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        tick_n(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_flags("rst");
        rst = 1'b0;
        tick_n(10);

        // 0x55 with a ready consumer
        send_frame(8'h55, BIT, 1'b0);
        wait_drain(200);
        tick_n(2);
        check("t1_valid_low", rx_valid, 1'b0);
        check_flags("t1");

        // Short low glitch: a false start, nothing delivered
        hold(1'b0, 12);
        check("t2_busy_high", busy, 1'b1);
        hold(1'b1, BIT);
        check("t2_busy_low", busy, 1'b0);
        check("t2_no_valid", rx_valid, 1'b0);

        // 0xA3 followed by a 20-bit break, then 0x3C
        send_body(8'hA3, BIT, 1'b0);
        hold(1'b0, 10 * BIT);
        check("t3_busy_break", busy, 1'b1);
        hold(1'b0, 10 * BIT);
        exp_frame = 1'b1;
        hold(1'b1, 2 * BIT);
        check_flags("t3_break");
        send_frame(8'h3C, BIT, 1'b0);
        wait_drain(200);
        check_flags("t3_after");
        pulse_clr();
        check_flags("t3_clr");

        // Two bytes into a stalled consumer: second is dropped
        rx_ready = 1'b0;
        send_frame(8'h11, BIT, 1'b0);
        send_frame(8'h22, BIT, 1'b0);
        tick_n(4);
        check("t4_rx_data", rx_data, 8'h11);
        check("t4_rx_valid", rx_valid, 1'b1);
        check_flags("t4_stall");
        exp_q.push_back(model_held);
        model_full = 1'b0;
        rx_ready   = 1'b1;
        tick_n(2);
        check("t4_valid_drop", rx_valid, 1'b0);
        check("t4_data_hold", rx_data, 8'h11);
        wait_drain(10);
        pulse_clr();
        check_flags("t4_clr");

        // Random bytes back to back with +/-3% transmitter bit period
        for (int k = 0; k < 80; k++) begin
            send_frame(8'($urandom), int'($urandom_range(62, 66)), 1'b0);
        end
        wait_drain(200);
        check_flags("t5");

`ifdef UART_RX_PARITY_EN
        // 0x80: wrong parity is discarded, correct parity is delivered
        send_frame(8'h80, BIT, 1'b1);
        tick_n(4);
        check("t6_no_valid", rx_valid, 1'b0);
        check_flags("t6_bad");
        send_frame(8'h80, BIT, 1'b0);
        wait_drain(200);
        check_flags("t6_good");
`endif

        tick_n(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
